// File: rtl/serial_complementor_if.sv
// Operand/result bundle for serial_complementor; one instance per unit.
// A request is taken on any rising edge where start=1 and busy=0 (a and mode sampled then); done is a one-cycle pulse carrying a new w/ovf, and start held during done chains the next request with no idle cycle.
interface serial_complementor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] w;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [1:0]       state_dbg;

  modport master (
    output start, mode, a,
    input  w, busy, done, ovf, state_dbg
  );

  modport slave (
    input  start, mode, a,
    output w, busy, done, ovf, state_dbg
  );
endinterface

// File: rtl/serial_complementor.sv
// Digit-serial two's-complement unit: pass, negate, abs and ones' complement,
// DIGIT bits per clock using a carried "seen-a-one" flag.
module serial_complementor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_complementor_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(N - 1);
  localparam logic [1:0]       M_NEG    = 2'b01;
  localparam logic [1:0]       M_ABS    = 2'b10;
  localparam logic [1:0]       M_ONES   = 2'b11;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [1:0]       mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             sign_q, sign_d;
  logic             mneg_q, mneg_d;
  logic             ovf_q, ovf_d;

  logic                   neg_eff;
  logic                   ripple;
  logic [DIGIT-1:0]       out_dig;
  logic [WIDTH+DIGIT-1:0] res_shift;

  // Abs behaves as negate only for negative operands, otherwise as pass.
  assign neg_eff = (mode_q == M_NEG) || ((mode_q == M_ABS) && sign_q);

  always_comb begin
    ripple  = flag_q;
    out_dig = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (neg_eff) begin
        out_dig[i] = opnd_q[i] ^ ripple;
        ripple     = ripple | opnd_q[i];
      end else if (mode_q == M_ONES) begin
        out_dig[i] = ~opnd_q[i];
      end else begin
        out_dig[i] = opnd_q[i];
      end
    end
    res_shift = {out_dig, res_q} >> DIGIT;
  end

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    w_d     = w_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    sign_d  = sign_q;
    mneg_d  = mneg_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          opnd_d  = bus.a;
          mode_d  = bus.mode;
          flag_d  = 1'b0;
          cnt_d   = '0;
          sign_d  = bus.a[WIDTH-1];
          mneg_d  = (bus.a == MOST_NEG);
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        opnd_d = opnd_q >> DIGIT;
        res_d  = res_shift[WIDTH-1:0];
        flag_d = ripple;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          w_d     = res_shift[WIDTH-1:0];
          ovf_d   = mneg_q && ((mode_q == M_NEG) || (mode_q == M_ABS));
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opnd_q  <= '0;
      res_q   <= '0;
      w_q     <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      sign_q  <= 1'b0;
      mneg_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      w_q     <= w_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      sign_q  <= sign_d;
      mneg_q  <= mneg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.w         = w_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_serial_complementor.sv
// Directed and randomised checks of serial_complementor at 8x1 and 16x4.
module tb_serial_complementor;
  localparam logic [1:0] M_PASS = 2'b00;
  localparam logic [1:0] M_NEG  = 2'b01;
  localparam logic [1:0] M_ABS  = 2'b10;
  localparam logic [1:0] M_ONES = 2'b11;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [8:0]  exp8_q[$];
  logic [16:0] exp16_q[$];
  logic [8:0]  e8;
  logic [16:0] e16;

  serial_complementor_if #(.WIDTH(8))  b8 ();
  serial_complementor_if #(.WIDTH(16)) b16 ();

  serial_complementor #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  serial_complementor #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && b8.done === 1'b1) begin
      if (exp8_q.size() == 0) begin
        check("dut8_spurious_done", 32'(b8.done), 32'd0);
      end else begin
        e8 = exp8_q.pop_front();
        check("dut8_w", 32'(b8.w), 32'(e8[7:0]));
        check("dut8_ovf", 32'(b8.ovf), 32'(e8[8]));
      end
    end
    if (rst === 1'b0 && b16.done === 1'b1) begin
      if (exp16_q.size() == 0) begin
        check("dut16_spurious_done", 32'(b16.done), 32'd0);
      end else begin
        e16 = exp16_q.pop_front();
        check("dut16_w", 32'(b16.w), 32'(e16[15:0]));
        check("dut16_ovf", 32'(b16.ovf), 32'(e16[16]));
      end
    end
  end

  // driver tasks
  task automatic wait_done8(input string tag, input bit drop_start, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        check({tag, "_busy"}, 32'(b8.busy), 32'd1);
        if (drop_start) begin
          b8.start = 1'b0;
          b8.a     = 8'($urandom_range(0, 255));
        end
      end
    end while (b8.done !== 1'b1 && cyc < 40);
    if (b8.done !== 1'b1) check({tag, "_timeout"}, 32'(b8.done), 32'd1);
  endtask

  task automatic op8(input string tag, input logic [1:0] m, input logic [7:0] av,
                     input logic [7:0] ew, input logic eo);
    int cyc;
    @(posedge clk);
    #1;
    b8.mode  = m;
    b8.a     = av;
    b8.start = 1'b1;
    exp8_q.push_back({eo, ew});
    wait_done8(tag, 1'b1, cyc);
    check({tag, "_lat"}, 32'(cyc), 32'd9);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(b8.done), 32'd0);
  endtask

  task automatic op16(input string tag, input logic [1:0] m, input logic [15:0] av,
                      input logic [15:0] ew, input logic eo);
    int cyc;
    @(posedge clk);
    #1;
    b16.mode  = m;
    b16.a     = av;
    b16.start = 1'b1;
    exp16_q.push_back({eo, ew});
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) b16.start = 1'b0;
    end while (b16.done !== 1'b1 && cyc < 40);
    if (b16.done !== 1'b1) check({tag, "_timeout"}, 32'(b16.done), 32'd1);
    check({tag, "_lat"}, 32'(cyc), 32'd5);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          cyc;
    logic [15:0] r;
    logic [15:0] rexp;
    logic [1:0]  rm;

    rst       = 1'b1;
    b8.start  = 1'b0;
    b8.mode   = M_PASS;
    b8.a      = '0;
    b16.start = 1'b0;
    b16.mode  = M_PASS;
    b16.a     = '0;
    #12;
    check("rst_w", 32'(b8.w), 32'd0);
    check("rst_busy", 32'(b8.busy), 32'd0);
    check("rst_done", 32'(b8.done), 32'd0);
    check("rst_ovf", 32'(b8.ovf), 32'd0);
    check("rst_state", 32'(b8.state_dbg), 32'd0);
    check("rst16_w", 32'(b16.w), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic negate boundaries
    op8("neg_ff", M_NEG, 8'hFF, 8'h01, 1'b0);
    op8("neg_00", M_NEG, 8'h00, 8'h00, 1'b0);
    op8("neg_80", M_NEG, 8'h80, 8'h80, 1'b1);
    op8("neg_7f", M_NEG, 8'h7F, 8'h81, 1'b0);

    // mode coverage
    op8("abs_f6", M_ABS, 8'hF6, 8'h0A, 1'b0);
    op8("abs_05", M_ABS, 8'h05, 8'h05, 1'b0);
    op8("abs_80", M_ABS, 8'h80, 8'h80, 1'b1);
    op8("ones_3c", M_ONES, 8'h3C, 8'hC3, 1'b0);
    op8("ones_80", M_ONES, 8'h80, 8'h7F, 1'b0);
    op8("pass_5a", M_PASS, 8'h5A, 8'h5A, 1'b0);
    op8("pass_80", M_PASS, 8'h80, 8'h80, 1'b0);

    // start during RUN is ignored
    @(posedge clk);
    #1;
    b8.mode  = M_NEG;
    b8.a     = 8'h01;
    b8.start = 1'b1;
    exp8_q.push_back({1'b0, 8'hFF});
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    b8.a     = 8'h02;
    b8.start = 1'b1;
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    check("ignore_busy", 32'(b8.busy), 32'd1);
    wait_done8("ignore", 1'b0, cyc);
    repeat (15) @(posedge clk);
    #1;
    check("ignore_queue", 32'(exp8_q.size()), 32'd0);

    // back-to-back with start held through done
    @(posedge clk);
    #1;
    b8.mode  = M_NEG;
    b8.a     = 8'h03;
    b8.start = 1'b1;
    exp8_q.push_back({1'b0, 8'hFD});
    exp8_q.push_back({1'b0, 8'hFD});
    wait_done8("b2b_first", 1'b0, cyc);
    check("b2b_first_lat", 32'(cyc), 32'd9);
    wait_done8("b2b_second", 1'b1, cyc);
    check("b2b_second_lat", 32'(cyc), 32'd9);
    @(posedge clk);
    #1;
    check("b2b_pulse", 32'(b8.done), 32'd0);
    check("b2b_queue", 32'(exp8_q.size()), 32'd0);

    // asynchronous reset in the middle of RUN
    @(posedge clk);
    #1;
    b8.mode  = M_NEG;
    b8.a     = 8'h7F;
    b8.start = 1'b1;
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_w", 32'(b8.w), 32'd0);
    check("arst_busy", 32'(b8.busy), 32'd0);
    check("arst_done", 32'(b8.done), 32'd0);
    check("arst_state", 32'(b8.state_dbg), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("arst_no_done", 32'(b8.done), 32'd0);
    op8("arst_fresh", M_NEG, 8'h7F, 8'h81, 1'b0);

    // 16-bit, 4 bits per clock
    op16("w16_neg_1234", M_NEG, 16'h1234, 16'hEDCC, 1'b0);
    op16("w16_neg_8000", M_NEG, 16'h8000, 16'h8000, 1'b1);
    op16("w16_neg_0000", M_NEG, 16'h0000, 16'h0000, 1'b0);
    op16("w16_ones_00ff", M_ONES, 16'h00FF, 16'hFF00, 1'b0);
    for (int i = 0; i < 12; i++) begin
      r    = 16'($urandom_range(0, 65535));
      rm   = (i % 3 == 2) ? M_ABS : M_NEG;
      rexp = ~r + 16'd1;
      if (rm == M_ABS && r[15] == 1'b0) rexp = r;
      op16("w16_rand", rm, r, rexp, (r == 16'h8000));
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_queue8", 32'(exp8_q.size()), 32'd0);
    check("final_queue16", 32'(exp16_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
